// File: rtl/packet_framer.sv
// Word-to-packet framer: a fill buffer collects words and a hold buffer presents
// closed packets to the consumer until they are acknowledged.
module packet_framer #(
  parameter int                    WORD_WIDTH   = 8,
  parameter int                    PACKET_WIDTH = 4,
  parameter int                    TIMEOUT      = 0,
  parameter logic [WORD_WIDTH-1:0] PAD_WORD     = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [WORD_WIDTH-1:0]              word,
  input  logic                               write,
  input  logic                               flush,
  input  logic                               ack,
  output logic [PACKET_WIDTH*WORD_WIDTH-1:0] sys_packet,
  output logic [$clog2(PACKET_WIDTH+1)-1:0]  packet_len,
  output logic                               send,
  output logic                               overflow
);
  localparam int LW = $clog2(PACKET_WIDTH+1);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;

  typedef enum logic {FILLING, CLOSED} fill_e;
  typedef enum logic {EMPTY, VALID}    hold_e;

  fill_e r_fst, w_fst_nxt;
  hold_e r_hst, w_hst_nxt;

  logic [PACKET_WIDTH-1:0][WORD_WIDTH-1:0] r_fill, w_fill_nxt;
  logic [PACKET_WIDTH-1:0][WORD_WIDTH-1:0] r_hold, w_hold_nxt;
  logic [PACKET_WIDTH-1:0][WORD_WIDTH-1:0] w_pkt;
  logic [LW-1:0] r_idx, w_idx_nxt;
  logic [LW-1:0] r_clen, w_clen_nxt;
  logic [LW-1:0] r_hlen, w_hlen_nxt;
  logic [LW-1:0] w_len;
  logic          r_ovf, w_ovf_nxt;
  logic          w_free, w_last, w_close, w_to;

  // Hold can take a new packet if empty or being acknowledged on this edge.
  assign w_free  = (r_hst == EMPTY) || ack;
  assign w_last  = write && (r_idx == LW'(PACKET_WIDTH-1));
  assign w_len   = r_idx + {{(LW-1){1'b0}}, write};
  assign w_close = (r_fst == FILLING) &&
                   (w_last || (flush && ((r_idx != '0) || write)) || w_to);

  generate
    if (TIMEOUT > 0) begin : g_to
      logic [CW-1:0] r_idle;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_idle <= '0;
        else if ((r_fst != FILLING) || write || (r_idx == '0) || w_close)
          r_idle <= '0;
        else
          r_idle <= r_idle + CW'(1);
      end
      assign w_to = (r_fst == FILLING) && !write && (r_idx != '0) &&
                    (r_idle == CW'(TIMEOUT-1));
    end else begin : g_no_to
      assign w_to = 1'b0;
    end
  endgenerate

  // Packet image as it would look after this cycle's write, padded past w_len.
  always_comb begin
    w_pkt = '0;
    for (int i = 0; i < PACKET_WIDTH; i++) begin
      if (LW'(i) < w_len)
        w_pkt[i] = (write && (LW'(i) == r_idx)) ? word : r_fill[i];
      else
        w_pkt[i] = PAD_WORD;
    end
  end

  always_comb begin
    w_fst_nxt  = r_fst;
    w_hst_nxt  = r_hst;
    w_fill_nxt = r_fill;
    w_idx_nxt  = r_idx;
    w_clen_nxt = r_clen;
    w_hold_nxt = r_hold;
    w_hlen_nxt = r_hlen;
    w_ovf_nxt  = 1'b0;
    if ((r_hst == VALID) && ack)
      w_hst_nxt = EMPTY;
    case (r_fst)
      FILLING: begin
        if (write) begin
          for (int i = 0; i < PACKET_WIDTH; i++)
            if (LW'(i) == r_idx) w_fill_nxt[i] = word;
          w_idx_nxt = r_idx + LW'(1);
        end
        if (w_close) begin
          w_idx_nxt = '0;
          if (w_free) begin
            w_hold_nxt = w_pkt;
            w_hlen_nxt = w_len;
            w_hst_nxt  = VALID;
          end else begin
            w_fill_nxt = w_pkt;
            w_clen_nxt = w_len;
            w_fst_nxt  = CLOSED;
          end
        end
      end
      CLOSED: begin
        // Writes are dropped here, including on the edge the packet leaves.
        w_ovf_nxt = write;
        if (w_free) begin
          w_hold_nxt = r_fill;
          w_hlen_nxt = r_clen;
          w_hst_nxt  = VALID;
          w_fst_nxt  = FILLING;
          w_idx_nxt  = '0;
        end
      end
      default: w_fst_nxt = FILLING;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fst  <= FILLING;
      r_hst  <= EMPTY;
      r_fill <= '0;
      r_hold <= '0;
      r_idx  <= '0;
      r_clen <= '0;
      r_hlen <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_fst  <= w_fst_nxt;
      r_hst  <= w_hst_nxt;
      r_fill <= w_fill_nxt;
      r_hold <= w_hold_nxt;
      r_idx  <= w_idx_nxt;
      r_clen <= w_clen_nxt;
      r_hlen <= w_hlen_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

  assign sys_packet = r_hold;
  assign packet_len = r_hlen;
  assign send       = (r_hst == VALID);
  assign overflow   = r_ovf;
endmodule

// File: tb/tb_packet_framer.sv
// Bench for packet_framer: a default instance and a TIMEOUT=5 instance share
// stimulus; both are compared against a word-queue model of the framing rules.
module tb_packet_framer;
  localparam int W  = 8;
  localparam int PW = 4;
  localparam int LW = $clog2(PW+1);
  localparam logic [W-1:0] PAD = '0;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] word;
  logic write, flush, ack;
  logic [1:0][PW*W-1:0] pkt;
  logic [1:0][LW-1:0]   plen;
  logic [1:0]           send, ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  packet_framer u_dut0 (
    .clk(clk), .rst(rst), .word(word), .write(write), .flush(flush), .ack(ack),
    .sys_packet(pkt[0]), .packet_len(plen[0]), .send(send[0]), .overflow(ovf[0])
  );

  packet_framer #(.WORD_WIDTH(W), .PACKET_WIDTH(PW), .TIMEOUT(5), .PAD_WORD(PAD)) u_dut1 (
    .clk(clk), .rst(rst), .word(word), .write(write), .flush(flush), .ack(ack),
    .sys_packet(pkt[1]), .packet_len(plen[1]), .send(send[1]), .overflow(ovf[1])
  );

  // Model state: partial words, a pending closed packet, and the presented packet.
  logic [W-1:0]    m_fill [2][PW];
  int              m_cnt  [2];
  int              m_idle [2];
  bit              m_cv   [2];
  logic [PW*W-1:0] m_cp   [2];
  int              m_cl   [2];
  bit              m_hv   [2];
  logic [PW*W-1:0] m_hp   [2];
  int              m_hl   [2];
  bit              m_ov   [2];

  function automatic int to_of(input int m);
    return (m == 0) ? 0 : 5;
  endfunction

  function automatic logic [PW*W-1:0] build(input int m);
    logic [PW*W-1:0] p;
    p = '0;
    for (int i = 0; i < PW; i++)
      p[i*W +: W] = (i < m_cnt[m]) ? m_fill[m][i] : PAD;
    return p;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_idle[m] = 0; m_cv[m] = 0; m_hv[m] = 0; m_ov[m] = 0;
      m_cp[m] = '0; m_cl[m] = 0; m_hp[m] = '0; m_hl[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    bit free, close;
    logic [PW*W-1:0] p;
    free = !m_hv[m] || ack;
    m_ov[m] = 0;
    if (m_cv[m]) begin
      m_ov[m] = write;
      if (free) begin
        m_hv[m] = 1; m_hp[m] = m_cp[m]; m_hl[m] = m_cl[m]; m_cv[m] = 0;
      end
    end else begin
      close = 0;
      if (write) begin
        m_fill[m][m_cnt[m]] = word;
        m_cnt[m]++;
        m_idle[m] = 0;
      end else if (m_cnt[m] > 0) begin
        m_idle[m]++;
      end
      if (m_cnt[m] == PW) close = 1;
      if (flush && m_cnt[m] > 0) close = 1;
      if (to_of(m) > 0 && m_idle[m] == to_of(m)) close = 1;
      if (close) begin
        p = build(m);
        if (free) begin
          m_hv[m] = 1; m_hp[m] = p; m_hl[m] = m_cnt[m];
        end else begin
          m_cv[m] = 1; m_cp[m] = p; m_cl[m] = m_cnt[m];
        end
        m_cnt[m] = 0; m_idle[m] = 0;
      end else if (m_hv[m] && ack) begin
        m_hv[m] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("send%0d", m), 64'(send[m]), 64'(m_hv[m]));
      chk($sformatf("ovf%0d", m), 64'(ovf[m]), 64'(m_ov[m]));
      if (m_hv[m]) begin
        chk($sformatf("pkt%0d", m), 64'(pkt[m]), 64'(m_hp[m]));
        chk($sformatf("len%0d", m), 64'(plen[m]), 64'(m_hl[m]));
      end
    end
  endtask

  task automatic tick(input bit w, input logic [W-1:0] d, input bit f, input bit a);
    write = w; word = d; flush = f; ack = a;
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_step(m);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst_send%0d", m), 64'(send[m]), 64'd0);
      chk($sformatf("rst_len%0d", m), 64'(plen[m]), 64'd0);
      chk($sformatf("rst_pkt%0d", m), 64'(pkt[m]), 64'd0);
      chk($sformatf("rst_ovf%0d", m), 64'(ovf[m]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] wd [12];
    int n_ovf0, n_ovf1, n_send;
    rst = 1'b1; word = '0; write = 0; flush = 0; ack = 0;
    model_reset();
    #3;
    chk("reset_send", 64'(send), 64'd0);
    chk("reset_len0", 64'(plen[0]), 64'd0);
    chk("reset_pkt0", 64'(pkt[0]), 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full packet with ack high.
    tick(1, 8'h11, 0, 1);
    tick(1, 8'h22, 0, 1);
    tick(1, 8'h33, 0, 1);
    chk("full_nosend", 64'(send[0]), 64'd0);
    tick(1, 8'h44, 0, 1);
    chk("full_send", 64'(send[0]), 64'd1);
    chk("full_pkt", 64'(pkt[0]), 64'h44332211);
    chk("full_len", 64'(plen[0]), 64'd4);
    tick(0, 8'h00, 0, 1);
    chk("full_oneshot", 64'(send[0]), 64'd0);

    // Flush of a partial packet, then flush at index 0.
    tick(1, 8'hAA, 0, 1);
    tick(1, 8'hBB, 0, 1);
    tick(0, 8'h00, 1, 1);
    chk("flush_pkt", 64'(pkt[0]), 64'h0000BBAA);
    chk("flush_len", 64'(plen[0]), 64'd2);
    tick(0, 8'h00, 1, 1);
    chk("flush_empty", 64'(send[0]), 64'd0);
    tick(0, 8'h00, 1, 1);
    chk("flush_empty2", 64'(send), 64'd0);

    // Timeout on instance 1 only.
    tick(1, 8'h5A, 0, 1);
    for (int i = 0; i < 4; i++) tick(0, 8'h00, 0, 1);
    chk("to_early", 64'(send[1]), 64'd0);
    tick(0, 8'h00, 0, 1);
    chk("to_send", 64'(send[1]), 64'd1);
    chk("to_len", 64'(plen[1]), 64'd1);
    chk("to_pkt", 64'(pkt[1]), 64'h0000005A);
    chk("to_off", 64'(send[0]), 64'd0);
    tick(0, 8'h00, 1, 1);
    tick(0, 8'h00, 0, 1);

    // Back-pressure: 12 writes with ack low.
    n_ovf0 = 0; n_ovf1 = 0;
    for (int i = 0; i < 12; i++) begin
      wd[i] = 8'($urandom);
      tick(1, wd[i], 0, 0);
      n_ovf0 += int'(ovf[0]);
      n_ovf1 += int'(ovf[1]);
    end
    chk("bp_ovf0", 64'(n_ovf0), 64'd4);
    chk("bp_ovf1", 64'(n_ovf1), 64'd4);
    chk("bp_pkt1", 64'(pkt[0]), 64'({wd[3], wd[2], wd[1], wd[0]}));
    tick(0, 8'h00, 0, 1);
    chk("bp_send2", 64'(send[0]), 64'd1);
    chk("bp_pkt2", 64'(pkt[0]), 64'({wd[7], wd[6], wd[5], wd[4]}));
    tick(0, 8'h00, 0, 1);
    chk("bp_drain", 64'(send), 64'd0);

    // Reset during send with a partial fill pending.
    for (int i = 0; i < 6; i++) tick(1, 8'($urandom), 0, 0);
    chk("mid_send", 64'(send), 64'd3);
    do_reset();
    tick(1, 8'hC1, 0, 1);
    tick(1, 8'hC2, 0, 1);
    tick(1, 8'hC3, 0, 1);
    tick(1, 8'hC4, 0, 1);
    chk("post_rst_pkt", 64'(pkt[0]), 64'hC4C3C2C1);
    chk("post_rst_len", 64'(plen[1]), 64'd4);

    // Randomised traffic: busy phase then sparse phase to exercise timeouts.
    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 50);
    for (int i = 0; i < 300; i++)
      tick($urandom_range(0, 99) < 15, 8'($urandom), $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 70);

    // Back-to-back streaming with ack tied high.
    do_reset();
    n_send = 0; n_ovf0 = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1, 8'($urandom), 0, 1);
      n_send += int'(send[0]);
      n_ovf0 += int'(ovf[0]);
    end
    chk("b2b_sends", 64'(n_send), 64'd3);
    chk("b2b_ovf", 64'(n_ovf0), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/packet_framer.md
PACKET_FRAMER -- requirements
Module: packet_framer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8: bits per input word.
REQ-002 SHALL have parameter PACKET_WIDTH, default 4: words per packet (>=2).
REQ-003 SHALL have parameter TIMEOUT, default 0: idle cycles before auto-flush of a partial packet; 0 disables it.
REQ-004 SHALL have parameter PAD_WORD, default 0: value placed in unused word slots.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 word  input  WORD_WIDTH  data word to append.
REQ-008 write  input  1  appends word this cycle when high.
REQ-009 flush  input  1  closes the current partial packet.
REQ-010 ack  input  1  consumer accepts the presented packet.
REQ-011 sys_packet  output  PACKET_WIDTH*WORD_WIDTH  packet; word 0 in the least-significant slot.
REQ-012 packet_len  output  clog2(PACKET_WIDTH+1)  count of valid words in sys_packet.
REQ-013 send  output  1  sys_packet/packet_len valid; held until ack.
REQ-014 overflow  output  1  one-cycle pulse when a write is dropped.

Function
REQ-015 SHALL contain a fill buffer with index 0..PACKET_WIDTH-1 and a hold buffer driving sys_packet/packet_len.
REQ-016 Fill FSM SHALL have states FILLING and CLOSED; hold FSM SHALL have states EMPTY and VALID; send = (hold == VALID).
REQ-017 In FILLING, write SHALL store word at slot index and increment index.
REQ-018 A write at index PACKET_WIDTH-1 SHALL close the fill with length PACKET_WIDTH.
REQ-019 flush with index>0 (after any same-cycle write) SHALL close the fill with length index, or index+1 if write is also high; flush with index 0 and no write SHALL be ignored.
REQ-020 With TIMEOUT>0, an idle counter SHALL count cycles without write while index>0, clear on write, and close the fill when it reaches TIMEOUT.
REQ-021 On close, slots at and above the length SHALL be loaded with PAD_WORD.
REQ-022 A closed fill SHALL move to hold on the same edge if hold is EMPTY or ack is high with send high; otherwise fill SHALL enter CLOSED.
REQ-023 In CLOSED, the fill SHALL move to hold on the first edge where hold is EMPTY or acked, then return to FILLING with index 0.
REQ-024 A write arriving in CLOSED SHALL be dropped and SHALL pulse overflow for one cycle.
REQ-025 A write on the edge the fill leaves CLOSED SHALL still be dropped with overflow.
REQ-026 Latency: the completing write at edge N SHALL give send=1 after edge N when hold was free.
REQ-027 ack while send=1 with no transfer SHALL set hold EMPTY and send=0 after that edge.
REQ-028 ack while send=0 SHALL be ignored.
REQ-029 sys_packet and packet_len SHALL remain stable while send=1 and not acked.
REQ-030 Back-to-back: with ack tied high, PACKET_WIDTH consecutive writes SHALL produce one packet every PACKET_WIDTH cycles with no drops.

Reset
REQ-031 rst high SHALL immediately clear index, idle counter, both FSMs (FILLING, EMPTY), sys_packet=0, packet_len=0, send=0, overflow=0.
REQ-032 Reset mid-packet SHALL discard partial and held data; first word after release SHALL go to slot 0.

Verification
REQ-033 Defaults; ack high; write 0x11,0x22,0x33,0x44 -> send=1 for one cycle after the 4th write; sys_packet=0x44332211; packet_len=4.
REQ-034 Write 0xAA,0xBB, then flush -> sys_packet=0x0000BBAA; packet_len=2; flush at index 0 -> no send.
REQ-035 TIMEOUT=5; write 0x5A, then idle -> send rises 5 cycles after the write; packet_len=1; sys_packet=0x0000005A.
REQ-036 ack low; write 12 words -> 1st packet in hold, 2nd in CLOSED, 9th-12th writes dropped with 4 overflow pulses; on ack, packet 2 presented next cycle.
REQ-037 rst asserted after 2 writes and during send=1 -> send=0, packet_len=0 at once; the next 4 writes form a clean packet.
